// File: rtl/seg_display_sched.sv
// Round-robin scheduler that time-shares a four-digit active-low seven-segment display
// among N_SRC 13-bit sources using a sequential double-dabble converter.
// Optional build macro SEG_LZ_BLANK_EN enables leading-zero suppression on hex3..hex1.
module seg_display_sched #(
  parameter int N_SRC       = 4,
  parameter int VAL_W       = 13,
  parameter int HOLD_CYCLES = 50000000
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [N_SRC-1:0]       i_req,
  input  logic [N_SRC*VAL_W-1:0] i_val,
  output logic [N_SRC-1:0]       o_grant,
  output logic [2:0]             o_src,
  output logic                   o_busy,
  output logic [6:0]             o_hex3,
  output logic [6:0]             o_hex2,
  output logic [6:0]             o_hex1,
  output logic [6:0]             o_hex0
);

  localparam int         IDX_W     = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int         HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [3:0] LAST_ITER = 4'(VAL_W);
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_SHOW} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [N_SRC-1:0]   grant_q, grant_d;
  logic [2:0]         src_q, src_d;
  logic               busy_q, busy_d;
  logic [6:0]         hex3_q, hex3_d, hex2_q, hex2_d, hex1_q, hex1_d, hex0_q, hex0_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [3:0]         iter_q, iter_d;
  logic [15:0]        bcd_q, bcd_d;
  logic [VAL_W-1:0]   bin_q, bin_d;

  logic [VAL_W-1:0]   src_val [N_SRC];
  logic [IDX_W:0]     arb_cand;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_found;
  logic               hold_done;
  logic               grant_take;
  logic [15:0]        bcd_adj;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h58;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  // Double-dabble correction: any nibble >= 5 gets +3 so the next shift carries into BCD.
  function automatic logic [15:0] bcd_adjust(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int n = 0; n < 4; n++) begin
      if (b[n*4 +: 4] >= 4'd5) r[n*4 +: 4] = b[n*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  always_comb begin
    for (int k = 0; k < N_SRC; k++) src_val[k] = i_val[k*VAL_W +: VAL_W];
  end

  // First requester at or after the pointer, wrapping modulo N_SRC.
  // NOTE: every comb output gets a default before any conditional write, so no latch is inferred.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_cand  = '0;
    for (int off = 0; off < N_SRC; off++) begin
      arb_cand = {1'b0, ptr_q} + (IDX_W+1)'(off);
      if (arb_cand >= (IDX_W+1)'(N_SRC)) arb_cand = arb_cand - (IDX_W+1)'(N_SRC);
      if (!arb_found && i_req[arb_cand[IDX_W-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = arb_cand[IDX_W-1:0];
      end
    end
  end

  assign hold_done = (hold_q == HOLD_W'(HOLD_CYCLES - 1));
  assign bcd_adj   = bcd_adjust(bcd_q);

  // NOTE: state lives in non-blocking assignments only; all combinational work is done above.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      src_q   <= '0;
      busy_q  <= 1'b0;
      hex3_q  <= SEG_BLANK;
      hex2_q  <= SEG_BLANK;
      hex1_q  <= SEG_BLANK;
      hex0_q  <= SEG_BLANK;
      hold_q  <= '0;
      iter_q  <= '0;
      bcd_q   <= '0;
      bin_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      src_q   <= src_d;
      busy_q  <= busy_d;
      hex3_q  <= hex3_d;
      hex2_q  <= hex2_d;
      hex1_q  <= hex1_d;
      hex0_q  <= hex0_d;
      hold_q  <= hold_d;
      iter_q  <= iter_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (arb_found) state_d = S_CONVERT;
      S_CONVERT: if (iter_q == LAST_ITER) state_d = S_SHOW;
      S_SHOW:    if (hold_done) state_d = arb_found ? S_CONVERT : S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ptr_d   = ptr_q;
    grant_d = grant_q;
    src_d   = src_q;
    busy_d  = busy_q;
    hex3_d  = hex3_q;
    hex2_d  = hex2_q;
    hex1_d  = hex1_q;
    hex0_d  = hex0_q;
    hold_d  = hold_q;
    iter_d  = iter_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;

    grant_take = arb_found &&
                 ((state_q == S_IDLE) || ((state_q == S_SHOW) && hold_done));

    case (state_q)
      S_CONVERT: begin
        if (iter_q != LAST_ITER) begin
          bcd_d  = {bcd_adj[14:0], bin_q[VAL_W-1]};
          bin_d  = {bin_q[VAL_W-2:0], 1'b0};
          iter_d = iter_q + 4'd1;
        end else begin
          // All four digits load on one edge so the display never shows a mixed value.
`ifdef SEG_LZ_BLANK_EN
          hex3_d = (bcd_q[15:12] == 4'd0) ? SEG_BLANK : seg7(bcd_q[15:12]);
          hex2_d = (bcd_q[15:8]  == 8'd0) ? SEG_BLANK : seg7(bcd_q[11:8]);
          hex1_d = (bcd_q[15:4]  == 12'd0) ? SEG_BLANK : seg7(bcd_q[7:4]);
`else
          hex3_d = seg7(bcd_q[15:12]);
          hex2_d = seg7(bcd_q[11:8]);
          hex1_d = seg7(bcd_q[7:4]);
`endif
          hex0_d = seg7(bcd_q[3:0]);
          busy_d = 1'b0;
          hold_d = '0;
        end
      end
      S_SHOW: begin
        hold_d = hold_q + 1'b1;
        if (hold_done && !arb_found) grant_d = '0;
      end
      default: ;
    endcase

    if (grant_take) begin
      grant_d          = '0;
      grant_d[arb_idx] = 1'b1;
      src_d            = 3'(arb_idx);
      ptr_d            = (arb_idx == IDX_W'(N_SRC - 1)) ? '0 : arb_idx + 1'b1;
      bin_d            = src_val[arb_idx];
      bcd_d            = '0;
      iter_d           = '0;
      busy_d           = 1'b1;
    end
  end

  assign o_grant = grant_q;
  assign o_src   = src_q;
  assign o_busy  = busy_q;
  assign o_hex3  = hex3_q;
  assign o_hex2  = hex2_q;
  assign o_hex1  = hex1_q;
  assign o_hex0  = hex0_q;

endmodule

// File: tb/tb_seg_display_sched.sv
// Directed bench for seg_display_sched with HOLD_CYCLES=20; expectations are hand-computed.
// Honours SEG_LZ_BLANK_EN for the values that carry leading zeros.
module tb_seg_display_sched;

  localparam int N_SRC = 4;
  localparam int VAL_W = 13;
  localparam int HOLD  = 20;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [N_SRC-1:0]       req;
  logic [N_SRC*VAL_W-1:0] val;
  logic [N_SRC-1:0]       grant;
  logic [2:0]             src;
  logic                   busy;
  logic [6:0]             hex3, hex2, hex1, hex0;
  logic [27:0]            hex_all;

  int n_vec = 0;
  int n_err = 0;

  seg_display_sched #(.N_SRC(N_SRC), .VAL_W(VAL_W), .HOLD_CYCLES(HOLD)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_req   (req),
    .i_val   (val),
    .o_grant (grant),
    .o_src   (src),
    .o_busy  (busy),
    .o_hex3  (hex3),
    .o_hex2  (hex2),
    .o_hex1  (hex1),
    .o_hex0  (hex0)
  );

  always #5 clk = ~clk;

  assign hex_all = {hex3, hex2, hex1, hex0};

  function automatic logic [27:0] pk(input logic [6:0] h3, input logic [6:0] h2,
                                     input logic [6:0] h1, input logic [6:0] h0);
    return {h3, h2, h1, h0};
  endfunction

  localparam logic [27:0] EXP_BLANK = {7'h7F, 7'h7F, 7'h7F, 7'h7F};
  localparam logic [27:0] EXP_1234  = {7'h79, 7'h24, 7'h30, 7'h19};
  localparam logic [27:0] EXP_4321  = {7'h19, 7'h30, 7'h24, 7'h79};
  localparam logic [27:0] EXP_8191  = {7'h00, 7'h79, 7'h10, 7'h79};
  localparam logic [27:0] EXP_1807  = {7'h79, 7'h00, 7'h40, 7'h58};
`ifdef SEG_LZ_BLANK_EN
  localparam logic [27:0] EXP_0     = {7'h7F, 7'h7F, 7'h7F, 7'h40};
  localparam logic [27:0] EXP_5     = {7'h7F, 7'h7F, 7'h7F, 7'h12};
  localparam logic [27:0] EXP_42    = {7'h7F, 7'h7F, 7'h19, 7'h24};
  localparam logic [27:0] EXP_700   = {7'h7F, 7'h58, 7'h40, 7'h40};
`else
  localparam logic [27:0] EXP_0     = {7'h40, 7'h40, 7'h40, 7'h40};
  localparam logic [27:0] EXP_5     = {7'h40, 7'h40, 7'h40, 7'h12};
  localparam logic [27:0] EXP_42    = {7'h40, 7'h40, 7'h19, 7'h24};
  localparam logic [27:0] EXP_700   = {7'h40, 7'h58, 7'h40, 7'h40};
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    repeat (n) tick();
  endtask

  task automatic set_val(input int k, input logic [VAL_W-1:0] v);
    val[k*VAL_W +: VAL_W] = v;
  endtask

  logic [N_SRC-1:0] rr_grant [4];
  logic [27:0]      rr_hex   [4];

  initial begin
    rst_n = 1'b0;
    req   = '0;
    val   = '0;
    tick_n(2);

    check("rst_grant", 32'(grant), 32'h0);
    check("rst_src",   32'(src),   32'h0);
    check("rst_busy",  32'(busy),  32'h0);
    check("rst_hex",   32'(hex_all), 32'(EXP_BLANK));

    // Single requester, 1234, with the value changed right after the grant.
    rst_n = 1'b1;
    req   = 4'b0001;
    set_val(0, 13'd1234);
    tick();
    check("g0_grant", 32'(grant), 32'h1);
    check("g0_busy",  32'(busy),  32'h1);
    check("g0_src",   32'(src),   32'h0);
    set_val(0, 13'd4321);
    tick_n(13);
    check("conv13_busy", 32'(busy), 32'h1);
    check("conv13_hex",  32'(hex_all), 32'(EXP_BLANK));
    tick();
    check("disp_1234",  32'(hex_all), 32'(EXP_1234));
    check("disp_busy",  32'(busy), 32'h0);
    tick_n(HOLD - 1);
    check("hold_hex",   32'(hex_all), 32'(EXP_1234));
    check("hold_grant", 32'(grant), 32'h1);
    tick();
    check("regrant_busy",  32'(busy), 32'h1);
    check("regrant_grant", 32'(grant), 32'h1);
    check("regrant_hex",   32'(hex_all), 32'(EXP_1234));

    // Refresh shows the latest value; then no request at hold expiry.
    req = '0;
    tick_n(14);
    check("disp_4321", 32'(hex_all), 32'(EXP_4321));
    tick_n(HOLD);
    check("idle_grant", 32'(grant), 32'h0);
    check("idle_busy",  32'(busy),  32'h0);
    check("idle_hex",   32'(hex_all), 32'(EXP_4321));
    tick_n(7);
    check("idle7_grant", 32'(grant), 32'h0);

    // src2 requests, then drops three cycles into CONVERT.
    req = 4'b0100;
    set_val(2, 13'd700);
    set_val(3, 13'd1807);
    tick();
    check("g2_grant", 32'(grant), 32'h4);
    check("g2_src",   32'(src),   32'h2);
    tick_n(3);
    req = 4'b1011;
    tick_n(11);
    check("disp_700",  32'(hex_all), 32'(EXP_700));
    tick_n(HOLD - 1);
    check("hold_700",  32'(hex_all), 32'(EXP_700));
    check("hold_g2",   32'(grant), 32'h4);
    tick();
    check("skip2_grant", 32'(grant), 32'h8);
    check("skip2_src",   32'(src),   32'h3);

    // Reset at conversion iteration 6.
    tick_n(6);
    rst_n = 1'b0;
    #1;
    check("mrst_hex",   32'(hex_all), 32'(EXP_BLANK));
    check("mrst_grant", 32'(grant), 32'h0);
    check("mrst_busy",  32'(busy),  32'h0);
    check("mrst_src",   32'(src),   32'h0);
    tick();
    req = 4'b0010;
    set_val(1, 13'd42);
    rst_n = 1'b1;
    tick();
    check("g1_grant", 32'(grant), 32'h2);
    check("g1_src",   32'(src),   32'h1);
    tick_n(14);
    check("disp_42",  32'(hex_all), 32'(EXP_42));

    // Four simultaneous requesters from a fresh reset: strict round-robin.
    rst_n = 1'b0;
    tick();
    req = 4'b1111;
    set_val(0, 13'd8191);
    set_val(1, 13'd0);
    set_val(2, 13'd5);
    set_val(3, 13'd1807);
    rst_n = 1'b1;
    rr_grant[0] = 4'b0001; rr_hex[0] = EXP_8191;
    rr_grant[1] = 4'b0010; rr_hex[1] = EXP_0;
    rr_grant[2] = 4'b0100; rr_hex[2] = EXP_5;
    rr_grant[3] = 4'b1000; rr_hex[3] = EXP_1807;
    tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rr%0d_grant", i), 32'(grant), 32'(rr_grant[i]));
      tick_n(14);
      check($sformatf("rr%0d_hex", i), 32'(hex_all), 32'(rr_hex[i]));
      tick_n(HOLD);
    end
    check("rr_wrap_grant", 32'(grant), 32'h1);
    check("rr_wrap_hex",   32'(hex_all), 32'(EXP_1807));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
